// File: rtl/world_clock_pkg.sv
// Shared constants, types and wrap helpers for the multi-zone time-of-day engine.
package world_clock_pkg;

    localparam logic signed [12:0] MIN_PER_DAY = 13'sd1440;
    localparam logic signed [11:0] OFFSET_MIN  = -12'sd720;
    localparam logic signed [11:0] OFFSET_MAX  = 12'sd840;
    localparam logic [5:0]         SEC_MAX     = 6'd59;
    localparam logic [5:0]         MIN_MAX     = 6'd59;
    localparam logic [4:0]         HOUR_MAX    = 5'd23;

    typedef struct packed {
        logic [4:0] h;
        logic [5:0] m;
    } hm_t;

    typedef logic signed [1:0] day_carry_t;

    localparam day_carry_t DAY_PREV = -2'sd1;
    localparam day_carry_t DAY_SAME = 2'sd0;
    localparam day_carry_t DAY_NEXT = 2'sd1;

    function automatic logic offset_legal(input logic signed [11:0] off);
        return (off >= OFFSET_MIN) && (off <= OFFSET_MAX);
    endfunction

    function automatic logic [5:0] inc_wrap6(input logic [5:0] v, input logic [5:0] vmax);
        return (v >= vmax) ? 6'd0 : v + 6'd1;
    endfunction

    function automatic logic [4:0] inc_wrap5(input logic [4:0] v, input logic [4:0] vmax);
        return (v >= vmax) ? 5'd0 : v + 5'd1;
    endfunction

endpackage

// File: rtl/zone_offset_calc.sv
// Combinational zone time: base HH:MM plus a signed minute offset, folded into one day
// with a -1/0/+1 day carry.
module zone_offset_calc
    import world_clock_pkg::*;
(
    input  hm_t                base_hm,
    input  logic signed [11:0] offset,
    output hm_t                zone_hm,
    output day_carry_t         day
);

    logic [10:0]        base_min_s;
    logic signed [12:0] raw_s;
    logic signed [12:0] wrapped_s;

    // Minutes-of-day arithmetic and fold back into 0..1439
    always_comb begin
        base_min_s = ({6'd0, base_hm.h} * 11'd60) + {5'd0, base_hm.m};
        raw_s      = $signed({2'b00, base_min_s}) + $signed({offset[11], offset});
        if (raw_s < 13'sd0) begin
            wrapped_s = raw_s + MIN_PER_DAY;
            day       = DAY_PREV;
        end else if (raw_s >= MIN_PER_DAY) begin
            wrapped_s = raw_s - MIN_PER_DAY;
            day       = DAY_NEXT;
        end else begin
            wrapped_s = raw_s;
            day       = DAY_SAME;
        end
        zone_hm.h = 5'($unsigned(wrapped_s) / 13'd60);
        zone_hm.m = 6'($unsigned(wrapped_s) % 13'd60);
    end

endmodule

// File: rtl/multi_zone_clock.sv
// N-zone time-of-day engine: prescaled 1 Hz base clock with button adjust, per-zone
// signed minute offsets and registered zone HH:MM / day carry outputs.
module multi_zone_clock
    import world_clock_pkg::*;
#(
    parameter  int N_ZONES  = 4,
    parameter  int TICK_DIV = 100,
    localparam int ZW       = (N_ZONES > 1) ? $clog2(N_ZONES) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run,
    input  logic                 adj_hour,
    input  logic                 adj_min,
    input  logic                 off_we,
    input  logic [ZW-1:0]        off_zone,
    input  logic [11:0]          off_min,
    output logic                 sec_tick,
    output logic [4:0]           base_h,
    output logic [5:0]           base_m,
    output logic [5:0]           base_s,
    output logic [5*N_ZONES-1:0] zone_hours,
    output logic [6*N_ZONES-1:0] zone_mins,
    output logic [2*N_ZONES-1:0] zone_day,
    output logic                 day_pulse,
    output logic                 off_err
);

    localparam int             PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0]  PRESC_ONE  = PW'(1);

    logic [PW-1:0]        presc_q, presc_d;
    logic                 adj_hour_prev_q, adj_hour_prev_d;
    logic                 adj_min_prev_q, adj_min_prev_d;
    logic [4:0]           base_h_q, base_h_d;
    logic [5:0]           base_m_q, base_m_d;
    logic [5:0]           base_s_q, base_s_d;
    logic                 sec_tick_q, sec_tick_d;
    logic                 day_pulse_q, day_pulse_d;
    logic                 off_err_q, off_err_d;
    logic signed [11:0]   off_q [N_ZONES];
    logic signed [11:0]   off_d [N_ZONES];
    logic [5*N_ZONES-1:0] zone_hours_q, zone_hours_d;
    logic [6*N_ZONES-1:0] zone_mins_q, zone_mins_d;
    logic [2*N_ZONES-1:0] zone_day_q, zone_day_d;

    logic                 tick_s;
    logic                 hour_edge_s;
    logic                 min_edge_s;
    logic                 adjust_s;
    logic                 off_accept_s;
    hm_t                  base_hm_s;
    hm_t                  calc_hm_s  [N_ZONES];
    day_carry_t           calc_day_s [N_ZONES];

    // Prescaler, tick and button edge detection
    always_comb begin
        tick_s          = run && (presc_q == PRESC_LAST);
        adj_hour_prev_d = adj_hour;
        adj_min_prev_d  = adj_min;
        hour_edge_s     = adj_hour && !adj_hour_prev_q;
        min_edge_s      = adj_min && !adj_min_prev_q;
        adjust_s        = hour_edge_s || min_edge_s;
        if (!run) begin
            presc_d = presc_q;
        end else if (tick_s) begin
            presc_d = {PW{1'b0}};
        end else begin
            presc_d = presc_q + PRESC_ONE;
        end
    end

    // Base time: an adjust edge in the tick cycle wins and swallows that second
    always_comb begin
        base_h_d    = base_h_q;
        base_m_d    = base_m_q;
        base_s_d    = base_s_q;
        sec_tick_d  = 1'b0;
        day_pulse_d = 1'b0;
        if (adjust_s) begin
            if (min_edge_s) begin
                base_m_d = inc_wrap6(base_m_q, MIN_MAX);
                base_s_d = 6'd0;
            end else begin
                base_m_d = base_m_q;
                base_s_d = base_s_q;
            end
            if (hour_edge_s) begin
                base_h_d = inc_wrap5(base_h_q, HOUR_MAX);
            end else begin
                base_h_d = base_h_q;
            end
        end else if (tick_s) begin
            sec_tick_d = 1'b1;
            base_s_d   = inc_wrap6(base_s_q, SEC_MAX);
            if (base_s_q == SEC_MAX) begin
                base_m_d = inc_wrap6(base_m_q, MIN_MAX);
                if (base_m_q == MIN_MAX) begin
                    base_h_d    = inc_wrap5(base_h_q, HOUR_MAX);
                    day_pulse_d = (base_h_q == HOUR_MAX);
                end else begin
                    base_h_d = base_h_q;
                end
            end else begin
                base_m_d = base_m_q;
            end
        end else begin
            sec_tick_d = 1'b0;
        end
    end

    // Offset register file with range check on both index and value
    always_comb begin
        off_accept_s = off_we && (int'(off_zone) < N_ZONES) && offset_legal($signed(off_min));
        off_err_d    = off_we && !off_accept_s;
        for (int i = 0; i < N_ZONES; i++) begin
            if (off_accept_s && (int'(off_zone) == i)) begin
                off_d[i] = $signed(off_min);
            end else begin
                off_d[i] = off_q[i];
            end
        end
    end

    assign base_hm_s = {base_h_q, base_m_q};

    for (genvar g = 0; g < N_ZONES; g++) begin : g_zone
        zone_offset_calc u_calc (
            .base_hm (base_hm_s),
            .offset  (off_q[g]),
            .zone_hm (calc_hm_s[g]),
            .day     (calc_day_s[g])
        );
    end

    // Pack per-zone results into the flat output buses
    always_comb begin
        zone_hours_d = {(5*N_ZONES){1'b0}};
        zone_mins_d  = {(6*N_ZONES){1'b0}};
        zone_day_d   = {(2*N_ZONES){1'b0}};
        for (int i = 0; i < N_ZONES; i++) begin
            zone_hours_d[5*i +: 5] = calc_hm_s[i].h;
            zone_mins_d[6*i +: 6]  = calc_hm_s[i].m;
            zone_day_d[2*i +: 2]   = calc_day_s[i];
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q         <= {PW{1'b0}};
            adj_hour_prev_q <= 1'b0;
            adj_min_prev_q  <= 1'b0;
            base_h_q        <= 5'd0;
            base_m_q        <= 6'd0;
            base_s_q        <= 6'd0;
            sec_tick_q      <= 1'b0;
            day_pulse_q     <= 1'b0;
            off_err_q       <= 1'b0;
            zone_hours_q    <= {(5*N_ZONES){1'b0}};
            zone_mins_q     <= {(6*N_ZONES){1'b0}};
            zone_day_q      <= {(2*N_ZONES){1'b0}};
            for (int i = 0; i < N_ZONES; i++) begin
                off_q[i] <= 12'sd0;
            end
        end else begin
            presc_q         <= presc_d;
            adj_hour_prev_q <= adj_hour_prev_d;
            adj_min_prev_q  <= adj_min_prev_d;
            base_h_q        <= base_h_d;
            base_m_q        <= base_m_d;
            base_s_q        <= base_s_d;
            sec_tick_q      <= sec_tick_d;
            day_pulse_q     <= day_pulse_d;
            off_err_q       <= off_err_d;
            zone_hours_q    <= zone_hours_d;
            zone_mins_q     <= zone_mins_d;
            zone_day_q      <= zone_day_d;
            for (int i = 0; i < N_ZONES; i++) begin
                off_q[i] <= off_d[i];
            end
        end
    end

    assign sec_tick   = sec_tick_q;
    assign base_h     = base_h_q;
    assign base_m     = base_m_q;
    assign base_s     = base_s_q;
    assign zone_hours = zone_hours_q;
    assign zone_mins  = zone_mins_q;
    assign zone_day   = zone_day_q;
    assign day_pulse  = day_pulse_q;
    assign off_err    = off_err_q;

endmodule

// File: tb/tb_multi_zone_clock.sv
// Self-checking bench for multi_zone_clock: tick scoreboard plus directed zone/offset checks.
module tb_multi_zone_clock;

    localparam int NZ  = 5;
    localparam int TD  = 100;
    localparam int ZWB = 3;

    logic             clk = 1'b0;
    logic             reset, run, adj_hour, adj_min, off_we;
    logic [ZWB-1:0]   off_zone;
    logic [11:0]      off_min;
    logic             sec_tick, day_pulse, off_err;
    logic [4:0]       base_h;
    logic [5:0]       base_m, base_s;
    logic [5*NZ-1:0]  zone_hours;
    logic [6*NZ-1:0]  zone_mins;
    logic [2*NZ-1:0]  zone_day;

    multi_zone_clock #(.N_ZONES(NZ), .TICK_DIV(TD)) dut (
        .clk(clk), .reset(reset), .run(run), .adj_hour(adj_hour), .adj_min(adj_min),
        .off_we(off_we), .off_zone(off_zone), .off_min(off_min),
        .sec_tick(sec_tick), .base_h(base_h), .base_m(base_m), .base_s(base_s),
        .zone_hours(zone_hours), .zone_mins(zone_mins), .zone_day(zone_day),
        .day_pulse(day_pulse), .off_err(off_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] h;
        logic [5:0] m;
        logic [5:0] s;
        logic       dp;
    } tick_exp_t;

    tick_exp_t tick_q[$];
    int n_vec = 0;
    int n_err = 0;
    int exp_h = 0, exp_m = 0, exp_s = 0;
    int off_exp [NZ];

    task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every sec_tick pops the next expected base time from the scoreboard
    always @(negedge clk) begin
        tick_exp_t e;
        if (sec_tick === 1'b1) begin
            if (tick_q.size() == 0) begin
                chk_val("unexpected_sec_tick", 64'd1, 64'd0);
            end else begin
                e = tick_q.pop_front();
                chk_val("tick_time", 64'({base_h, base_m, base_s, day_pulse}),
                        64'({e.h, e.m, e.s, e.dp}));
            end
        end else if (day_pulse === 1'b1) begin
            chk_val("stray_day_pulse", 64'd1, 64'd0);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick_exp_t e;
            e.dp = 1'b0;
            exp_s++;
            if (exp_s == 60) begin
                exp_s = 0;
                exp_m++;
                if (exp_m == 60) begin
                    exp_m = 0;
                    exp_h++;
                    if (exp_h == 24) begin
                        exp_h = 0;
                        e.dp  = 1'b1;
                    end
                end
            end
            e.h = 5'(exp_h);
            e.m = 6'(exp_m);
            e.s = 6'(exp_s);
            tick_q.push_back(e);
        end
    endtask

    task automatic run_ticks(input int n);
        push_ticks(n);
        run = 1'b1;
        cyc(n * TD);
        run = 1'b0;
        cyc(1);
        chk_val("tick_q_drained", 64'(tick_q.size()), 64'd0);
    endtask

    task automatic press_hour();
        adj_hour = 1'b1; cyc(1);
        adj_hour = 1'b0; cyc(1);
        exp_h = (exp_h + 1) % 24;
    endtask

    task automatic press_min();
        adj_min = 1'b1; cyc(1);
        adj_min = 1'b0; cyc(1);
        exp_m = (exp_m + 1) % 60;
        exp_s = 0;
    endtask

    task automatic chk_base(input string tag);
        chk_val(tag, 64'({base_h, base_m, base_s}), 64'({5'(exp_h), 6'(exp_m), 6'(exp_s)}));
    endtask

    function automatic logic [12:0] zone_ref(input int h, input int m, input int off);
        int t, d;
        t = h * 60 + m + off;
        d = 0;
        if (t < 0) begin
            t += 1440; d = -1;
        end else if (t >= 1440) begin
            t -= 1440; d = 1;
        end
        return {5'(t / 60), 6'(t % 60), 2'(d)};
    endfunction

    function automatic logic [12:0] zone_obs(input int z);
        return {zone_hours[5*z +: 5], zone_mins[6*z +: 6], zone_day[2*z +: 2]};
    endfunction

    task automatic chk_zone(input string tag, input int z);
        chk_val(tag, 64'(zone_obs(z)), 64'(zone_ref(exp_h, exp_m, off_exp[z])));
    endtask

    task automatic write_off(input int z, input int off);
        logic legal;
        int   old_off;
        legal   = (z < NZ) && (off >= -720) && (off <= 840);
        old_off = (z < NZ) ? off_exp[z] : 0;
        off_we = 1'b1; off_zone = ZWB'(z); off_min = 12'(off);
        cyc(1);
        off_we = 1'b0;
        chk_val("off_err_pulse", 64'(off_err), legal ? 64'd0 : 64'd1);
        if (z < NZ) chk_val("zone_lag1", 64'(zone_obs(z)), 64'(zone_ref(exp_h, exp_m, old_off)));
        cyc(1);
        chk_val("off_err_clear", 64'(off_err), 64'd0);
        if (legal) off_exp[z] = off;
        if (z < NZ) chk_zone("zone_after_write", z);
    endtask

    task automatic wait_tick(input int budget, output int n);
        n = 0;
        while (n < budget && sec_tick !== 1'b1) begin
            cyc(1);
            n++;
        end
    endtask

    initial begin
        int n, dp_cnt;
        reset = 1'b1; run = 1'b0; adj_hour = 1'b0; adj_min = 1'b0;
        off_we = 1'b0; off_zone = '0; off_min = '0;
        for (int i = 0; i < NZ; i++) off_exp[i] = 0;
        cyc(3);
        chk_base("reset_base");
        chk_val("reset_zones", 64'({zone_hours, zone_mins, zone_day}), 64'd0);
        chk_val("reset_pulses", 64'({sec_tick, day_pulse, off_err}), 64'd0);
        reset = 1'b0;

        // 1: first second after reset
        push_ticks(1);
        run = 1'b1;
        cyc(TD - 1);
        chk_val("no_tick_early", 64'(sec_tick), 64'd0);
        cyc(1);
        chk_val("first_tick", 64'({sec_tick, base_s}), 64'({1'b1, 6'd1}));
        run = 1'b0;
        cyc(1);
        chk_val("tick_one_cycle", 64'(sec_tick), 64'd0);
        for (int z = 0; z < NZ; z++) chk_zone("zone_init", z);

        // 2: midnight rollover
        repeat (23) press_hour();
        repeat (59) press_min();
        chk_base("preload_2359");
        run_ticks(58);
        chk_base("preload_235958");
        push_ticks(2);
        run = 1'b1;
        dp_cnt = 0;
        for (int i = 0; i < 2 * TD; i++) begin
            cyc(1);
            if (day_pulse === 1'b1) dp_cnt++;
        end
        run = 1'b0;
        cyc(1);
        chk_val("day_pulse_count", 64'(dp_cnt), 64'd1);
        chk_base("midnight_base");
        chk_zone("midnight_zone0", 0);

        // 3: negative and maximum offsets at 01:30
        press_hour();
        repeat (30) press_min();
        chk_base("base_0130");
        write_off(1, -120);
        write_off(2, 840);

        // 4: 22:00, day +1, exact-boundary and rejected writes
        repeat (21) press_hour();
        repeat (30) press_min();
        chk_base("base_2200");
        write_off(3, 180);
        write_off(3, 900);
        write_off(NZ, 60);
        write_off(3, -721);
        write_off(4, -720);
        write_off(0, 120);
        for (int z = 0; z < NZ; z++) chk_zone("zone_all_2200", z);

        // 5: adjust colliding with a tick, held hour button
        repeat (12) press_hour();
        repeat (59) press_min();
        run_ticks(30);
        chk_base("base_105930");
        run = 1'b1;
        cyc(TD - 1);
        adj_min = 1'b1;
        cyc(1);
        exp_m = 0; exp_s = 0;
        chk_val("collide_no_tick", 64'(sec_tick), 64'd0);
        chk_base("collide_base");
        adj_min = 1'b0;
        push_ticks(1);
        wait_tick(TD + 50, n);
        chk_val("tick_gap_after_collide", 64'(n), 64'(TD));
        run = 1'b0;
        adj_hour = 1'b1;
        cyc(5);
        adj_hour = 1'b0;
        cyc(2);
        exp_h = (exp_h + 1) % 24;
        chk_base("held_hour_once");

        // 6: frozen prescaler, then reset mid-count with a concurrent write
        run = 1'b1;
        cyc(TD / 2);
        run = 1'b0;
        cyc(500);
        chk_base("frozen_base");
        push_ticks(1);
        run = 1'b1;
        wait_tick(TD + 50, n);
        chk_val("resume_gap", 64'(n), 64'(TD - TD / 2));
        cyc(30);
        chk_val("tick_q_before_reset", 64'(tick_q.size()), 64'd0);
        reset = 1'b1; off_we = 1'b1; off_zone = 3'd2; off_min = 12'd60;
        cyc(1);
        chk_val("midrst_base", 64'({base_h, base_m, base_s}), 64'd0);
        chk_val("midrst_zones", 64'({zone_hours, zone_mins, zone_day}), 64'd0);
        chk_val("midrst_pulses", 64'({sec_tick, day_pulse, off_err}), 64'd0);
        reset = 1'b0; off_we = 1'b0;
        exp_h = 0; exp_m = 0; exp_s = 0;
        for (int i = 0; i < NZ; i++) off_exp[i] = 0;
        push_ticks(1);
        wait_tick(TD + 50, n);
        chk_val("post_reset_gap", 64'(n), 64'(TD));
        run = 1'b0;
        cyc(2);
        chk_zone("write_in_reset_discarded", 2);
        chk_val("tick_q_final", 64'(tick_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
